// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sample BRAM between writer and reader.
// Optional macro ARB_WRITE_PRIORITY_EN: an eligible write always beats a read.
module mem_port_arbiter #(
  parameter int DEPTH  = 62500,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              full,
  output logic              empty,
  output logic              overrun
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WRITE    = 2'd1;
  localparam logic [1:0] S_RD_ISSUE = 2'd2;
  localparam logic [1:0] S_RD_WAIT  = 2'd3;

  localparam logic G_WRITE = 1'b0;
  localparam logic G_READ  = 1'b1;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] CMAX = ADDR_W'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              last_q, last_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] mwd_q, mwd_d;

  logic wr_elig, rd_elig, pick_w;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CMAX);
  assign empty   = (count_q == '0);
  assign wr_elig = wr_pend_q & ~full;
  assign rd_elig = rd_pend_q & ~empty;

`ifdef ARB_WRITE_PRIORITY_EN
  assign pick_w = 1'b1;
`else
  assign pick_w = (last_q == G_READ);
`endif

  assign overrun  = overrun_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // Scheduler: one memory access at a time, ties resolved by pick_w.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_d     = last_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_elig && rd_elig) begin
          last_d  = pick_w ? G_WRITE : G_READ;
          state_d = pick_w ? S_WRITE : S_RD_ISSUE;
        end else if (wr_elig) begin
          state_d = S_WRITE;
        end else if (rd_elig) begin
          state_d = S_RD_ISSUE;
        end
      end
      S_WRITE: begin
        wr_ptr_d = wrap_inc(wr_ptr_q);
        count_d  = count_q + 1'b1;
        state_d  = S_IDLE;
      end
      S_RD_ISSUE: begin
        rd_ptr_d = wrap_inc(rd_ptr_q);
        count_d  = count_q - 1'b1;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rd_data_d  = mem_rdata;
        rd_valid_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latches; a pulse on the clearing cycle counts as a fresh request.
  always_comb begin
    wr_pend_d = wr_pend_q & (state_q != S_WRITE);
    rd_pend_d = rd_pend_q & (state_q != S_RD_WAIT);
    wdata_d   = wdata_q;
    overrun_d = overrun_q;
    if (wr_req) begin
      if (wr_pend_d) begin
        overrun_d = 1'b1;
      end else begin
        wr_pend_d = 1'b1;
        wdata_d   = wr_data;
      end
    end
    if (rd_req) begin
      if (rd_pend_d) overrun_d = 1'b1;
      else           rd_pend_d = 1'b1;
    end
  end

  // Memory port drive; address and write data hold between accesses.
  always_comb begin
    mem_en    = (state_q == S_WRITE) | (state_q == S_RD_ISSUE);
    mem_we    = (state_q == S_WRITE);
    wr_ack    = (state_q == S_WRITE);
    mem_addr  = addr_q;
    mem_wdata = mwd_q;
    if (state_q == S_WRITE) begin
      mem_addr  = wr_ptr_q;
      mem_wdata = wdata_q;
    end else if (state_q == S_RD_ISSUE) begin
      mem_addr = rd_ptr_q;
    end
    addr_d = mem_addr;
    mwd_d  = mem_wdata;
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= G_READ;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      wdata_q    <= '0;
      overrun_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_q     <= '0;
      mwd_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      wdata_q    <= wdata_d;
      overrun_q  <= overrun_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_q     <= addr_d;
      mwd_q      <= mwd_d;
    end
  end

endmodule
